// File: rtl/lzx_cmp_pkg.sv
// -----------------------------------------------------------------------------
// lzx_cmp_pkg
//
// Shared types and constants for the nibble-serial magnitude comparator.
//
//   state_t  : FSM encoding of the serial comparator (IDLE -> RUN -> DONE).
//   casc_t   : 74HC85 cascade triple in the fixed bit order {g, e, l}.
//   CASC_GT  : A > B.
//   CASC_EQ  : A = B. This is the seed for a fresh comparison, because an
//              all-equal operand must resolve to "equal".
//   CASC_LT  : A < B.
//   is_one_hot(): true when exactly one cascade bit is set.
// -----------------------------------------------------------------------------
package lzx_cmp_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  typedef struct packed {
    logic g;
    logic e;
    logic l;
  } casc_t;

  localparam casc_t CASC_GT = 3'b100;
  localparam casc_t CASC_EQ = 3'b010;
  localparam casc_t CASC_LT = 3'b001;

  // The serial loop only ever loads CASC_EQ or a comparator output that was
  // computed from a one-hot input, so this holds for every cycle.
  function automatic logic is_one_hot(input casc_t c);
    return (c == CASC_GT) || (c == CASC_EQ) || (c == CASC_LT);
  endfunction

endpackage : lzx_cmp_pkg

// File: rtl/lzx_74HC85.sv
// -----------------------------------------------------------------------------
// lzx_74HC85
//
// Combinational model of one 4-bit 74HC85 magnitude comparator stage.
//
// Ports:
//   A, B            in  4 : operand nibbles, bit 3 is the MSB.
//   IA_g/IA_e/IA_l  in  1 : cascade inputs from the lower-order stage.
//   QA_g/QA_e/QA_l  out 1 : cascade outputs toward the higher-order stage.
//
// An unequal nibble decides the result on its own. An equal nibble passes
// the cascade inputs through. The multi-high and all-low input rows follow
// the device truth table, so this stage is a faithful drop-in for the part.
// -----------------------------------------------------------------------------
module lzx_74HC85 (
  input  logic [3:0] A,
  input  logic [3:0] B,
  input  logic       IA_g,
  input  logic       IA_e,
  input  logic       IA_l,
  output logic       QA_g,
  output logic       QA_e,
  output logic       QA_l
);

  always_comb begin
    // NOTE: every output gets a default before any branch, so no path through
    // this block can leave a value unassigned and infer a latch.
    QA_g = 1'b0;
    QA_e = 1'b0;
    QA_l = 1'b0;

    if (A > B) begin
      QA_g = 1'b1;
    end else if (A < B) begin
      QA_l = 1'b1;
    end else if (IA_e) begin
      QA_e = 1'b1;
    end else begin
      // Truth table for equal nibbles with IA_e low:
      //   g only -> g,   l only -> l,   g and l -> none,   neither -> g and l.
      QA_g = ~IA_l;
      QA_l = ~IA_g;
    end
  end

endmodule : lzx_74HC85

// File: rtl/lzx_serial_cmp.sv
// -----------------------------------------------------------------------------
// lzx_serial_cmp
//
// Nibble-serial magnitude comparator. A and B arrive one nibble per beat,
// least-significant nibble first. A single 74HC85 stage is reused: its
// outputs are registered and fed back into its own cascade inputs, so this
// block drives the cascade inputs the way a lower-order stage would. Because
// an unequal nibble overrides the cascade and an equal one passes it through,
// the last (most significant) unequal nibble decides the result.
//
// Parameters:
//   NIBBLES : operand width in nibbles (>= 1).
//   CW      : beat counter width. It is derived from NIBBLES; leave the
//             default in place.
//
// Ports:
//   clk          in  1 : clock, rising edge.
//   rst          in  1 : asynchronous active-high reset.
//   start        in  1 : begin a comparison; only sampled in IDLE.
//   in_valid     in  1 : a_nib/b_nib carry a beat.
//   in_ready     out 1 : beat accepted this cycle if in_valid; RUN only.
//   a_nib, b_nib in  4 : current operand nibbles.
//   busy         out 1 : comparison in progress (RUN or DONE).
//   done         out 1 : one-cycle pulse; res_* is final.
//   res_g/e/l    out 1 : one-hot result, held until the next final beat.
// -----------------------------------------------------------------------------
module lzx_serial_cmp
  import lzx_cmp_pkg::*;
#(
  parameter int NIBBLES = 4,
  parameter int CW      = $clog2(NIBBLES) + 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [3:0] a_nib,
  input  logic [3:0] b_nib,
  output logic       busy,
  output logic       done,
  output logic       res_g,
  output logic       res_e,
  output logic       res_l
);

  localparam logic [CW-1:0] LAST_BEAT = CW'(NIBBLES - 1);

  state_t        state;
  logic [CW-1:0] beat_cnt;
  casc_t         casc;
  casc_t         stage_q;
  logic          beat_acc;

  // The single reused comparator stage. Its cascade inputs come from the
  // registered result of the previous beat.
  lzx_74HC85 u_stage (
    .A    (a_nib),
    .B    (b_nib),
    .IA_g (casc.g),
    .IA_e (casc.e),
    .IA_l (casc.l),
    .QA_g (stage_q.g),
    .QA_e (stage_q.e),
    .QA_l (stage_q.l)
  );

  // in_ready is registered and is high exactly in RUN, so it doubles as the
  // state qualifier for the handshake.
  assign beat_acc = in_valid && in_ready;

  // FSM, beat counter, cascade register and result, with registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      // NOTE: sequential state uses non-blocking assignments only, so every
      // register samples pre-edge values regardless of statement order.
      state    <= ST_IDLE;
      beat_cnt <= '0;
      casc     <= CASC_EQ;
      in_ready <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      res_g    <= 1'b0;
      res_e    <= 1'b1;
      res_l    <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          // A beat presented together with start is not accepted, because
          // in_ready is still low in this cycle.
          if (start) begin
            state    <= ST_RUN;
            beat_cnt <= '0;
            casc     <= CASC_EQ;
            in_ready <= 1'b1;
            busy     <= 1'b1;
          end
        end

        ST_RUN: begin
          if (beat_acc) begin
            casc     <= stage_q;
            beat_cnt <= beat_cnt + 1'b1;
            if (beat_cnt == LAST_BEAT) begin
              res_g    <= stage_q.g;
              res_e    <= stage_q.e;
              res_l    <= stage_q.l;
              state    <= ST_DONE;
              in_ready <= 1'b0;
              done     <= 1'b1;
            end
          end
        end

        ST_DONE: begin
          state <= ST_IDLE;
          done  <= 1'b0;
          busy  <= 1'b0;
        end

        default: begin
          state    <= ST_IDLE;
          in_ready <= 1'b0;
          busy     <= 1'b0;
          done     <= 1'b0;
        end
      endcase
    end
  end

  // The feedback loop must never leave the one-hot set. The 74HC85
  // multi-high rows are then unreachable.
  always @(posedge clk) begin
    if (!rst) begin
      assert (is_one_hot(casc))
        else $error("cascade register not one-hot: %b", casc);
    end
  end

endmodule : lzx_serial_cmp

// File: tb/tb_lzx_serial_cmp.sv
// -----------------------------------------------------------------------------
// tb_lzx_serial_cmp
//
// Directed and random stimulus for lzx_serial_cmp with NIBBLES=4. A queue-based
// model collects the accepted beats, rebuilds the full operands and compares
// them as integers. A negedge process checks every output against the model
// on every cycle. Literal results pin the model on the directed cases.
// -----------------------------------------------------------------------------
module tb_lzx_serial_cmp;

  localparam int N = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic       in_valid;
  logic [3:0] a_nib;
  logic [3:0] b_nib;
  logic       in_ready;
  logic       busy;
  logic       done;
  logic       res_g;
  logic       res_e;
  logic       res_l;

  always #5 clk = ~clk;

  lzx_serial_cmp #(.NIBBLES(N)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .a_nib    (a_nib),
    .b_nib    (b_nib),
    .busy     (busy),
    .done     (done),
    .res_g    (res_g),
    .res_e    (res_e),
    .res_l    (res_l)
  );

  int n_vec = 0;
  int n_err = 0;
  int ops = 0;
  int dut_done_cnt = 0;
  bit chk_en = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %h want %h", name, $time, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  // phase: 0 idle, 1 collecting beats, 2 result cycle.
  int              m_phase;
  logic [3:0]      qa[$];
  logic [3:0]      qb[$];
  logic [2:0]      m_res;
  longint unsigned va, vb;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_phase = 0;
      qa.delete();
      qb.delete();
      m_res = 3'b010;
    end else begin
      case (m_phase)
        0: if (start) begin
          m_phase = 1;
          qa.delete();
          qb.delete();
        end
        1: if (in_valid) begin
          qa.push_back(a_nib);
          qb.push_back(b_nib);
          if (qa.size() == N) begin
            va = 0;
            vb = 0;
            for (int i = N - 1; i >= 0; i--) begin
              va = (va << 4) | longint'(qa[i]);
              vb = (vb << 4) | longint'(qb[i]);
            end
            m_res = (va > vb) ? 3'b100 : (va == vb) ? 3'b010 : 3'b001;
            m_phase = 2;
          end
        end
        default: m_phase = 0;
      endcase
    end
  end

  function automatic logic [31:0] exp_vec();
    return {26'b0, m_phase == 1, m_phase != 0, m_phase == 2, m_res};
  endfunction

  function automatic logic [31:0] dut_vec();
    return {26'b0, in_ready, busy, done, res_g, res_e, res_l};
  endfunction

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    if (chk_en) begin
      check("cycle", dut_vec(), exp_vec());
      if (done) dut_done_cnt++;
    end
  end

  // ---------------- stimulus ----------------
  // Called and returns at posedge+1. The start edge is followed by N beat
  // edges and then the DONE cycle. gap_len idle cycles go before beat gap_pos.
  task automatic run_op(input logic [15:0] a, input logic [15:0] b,
                        input int gap_pos, input int gap_len, input bit rnd,
                        input bit use_lit, input logic [2:0] lit);
    start    = 1'b1;
    in_valid = rnd ? 1'($urandom_range(0, 1)) : 1'b0;
    a_nib    = 4'($urandom);
    b_nib    = 4'($urandom);
    @(posedge clk); #1;
    start = 1'b0;
    for (int i = 0; i < N; i++) begin
      int g;
      if (rnd) g = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3)) : 0;
      else     g = (i == gap_pos) ? gap_len : 0;
      repeat (g) begin
        in_valid = 1'b0;
        a_nib    = 4'($urandom);
        b_nib    = 4'($urandom);
        start    = rnd ? 1'($urandom_range(0, 1)) : 1'b0;
        @(posedge clk); #1;
      end
      in_valid = 1'b1;
      a_nib    = a[4*i +: 4];
      b_nib    = b[4*i +: 4];
      start    = rnd ? 1'($urandom_range(0, 1)) : 1'b0;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    start    = rnd ? 1'($urandom_range(0, 1)) : 1'b0;
    @(negedge clk);
    check("done_pulse", {31'b0, done}, 32'd1);
    if (use_lit) begin
      check("model_res", {29'b0, m_res}, {29'b0, lit});
      check("dut_res", {29'b0, res_g, res_e, res_l}, {29'b0, lit});
    end
    ops++;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst      = 1'b1;
    start    = 1'b0;
    in_valid = 1'b0;
    a_nib    = 4'h0;
    b_nib    = 4'h0;
    @(posedge clk); #1;
    chk_en = 1'b1;
    check("reset_state", dut_vec(), 32'b000010);
    @(posedge clk); #2;
    rst = 1'b0;
    @(posedge clk); #1;

    // Directed cases with hand-computed results {g,e,l}.
    run_op(16'h1234, 16'h1234, 0, 0, 1'b0, 1'b1, 3'b010);
    run_op(16'h8000, 16'h7FFF, 0, 0, 1'b0, 1'b1, 3'b100);
    run_op(16'h0FFF, 16'h1000, 0, 0, 1'b0, 1'b1, 3'b001);
    run_op(16'hFFFE, 16'hFFFF, 0, 0, 1'b0, 1'b1, 3'b001);
    // Back-pressure: three idle cycles between the second and third beats.
    run_op(16'h8000, 16'h7FFF, 2, 3, 1'b0, 1'b1, 3'b100);

    // Reset mid-RUN after two beats; the previous result (g) must drop to e.
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int i = 0; i < 2; i++) begin
      in_valid = 1'b1;
      a_nib    = 4'h5;
      b_nib    = 4'h3;
      @(posedge clk); #1;
    end
    #2 rst = 1'b1;
    in_valid = 1'b0;
    #1;
    check("reset_async", dut_vec(), 32'b000010);
    #2 rst = 1'b0;
    @(posedge clk); #1;
    run_op(16'hABCD, 16'hABCC, 0, 0, 1'b0, 1'b1, 3'b100);

    // Random pairs with random gaps, stray start and beats offered with start.
    for (int k = 0; k < 1000; k++) begin
      logic [15:0] a, b;
      a = 16'($urandom);
      case ($urandom_range(0, 3))
        0:       b = a;
        1:       b = a ^ (16'h000F << (4 * $urandom_range(0, 3)));
        default: b = 16'($urandom);
      endcase
      run_op(a, b, 0, 0, 1'b1, 1'b0, 3'b000);
      repeat ($urandom_range(0, 2)) begin
        @(posedge clk); #1;
      end
    end

    @(negedge clk);
    check("done_count", dut_done_cnt, ops);
    chk_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule : tb_lzx_serial_cmp
